reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file: configurable data width and depth, two combinational read ports and one synchronous write port.
- Adds an optional write-to-read bypass, a per-register pending-write scoreboard for multi-cycle/pipelined datapaths, and a sequential clear engine with a busy/done handshake.
- Sits between decode (read addresses, scoreboard issue) and writeback (write port) in the datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NREG = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy outputs
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset (see Behaviour)
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
rd1  out  DATA_W  read data, port 1 (combinational)
rd2  out  DATA_W  read data, port 2 (combinational)
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
sb_set  in  1  mark register sb_addr as pending (producer issued)
sb_addr  in  ADDR_W  scoreboard set address
busy1  out  1  pending status of ra1 (combinational)
busy2  out  1  pending status of ra2 (combinational)
clr_req  in  1  request sequential clear of all registers
clr_busy  out  1  clear engine active (registered)
clr_done  out  1  one-cycle pulse when clear completes (registered)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asynchronous):
  - All registers 0; all pending bits 0; FSM to IDLE; clear counter 0.
  - clr_busy=0, clr_done=0; rd1/rd2 read 0; busy1/busy2 read 0.
- Effective write: we=1, FSM=IDLE, and not (ZERO_REG=1 and wa=0). Commits at the rising edge; data visible through storage from the next cycle.
- Read, per port p:
  - rdp = stored[rap].
  - If BYPASS=1 and an effective write targets rap this cycle: rdp = wd.
  - If ZERO_REG=1 and rap=0: rdp = 0, regardless of write or bypass.
  - Both ports may use the same address; each resolves independently.
- Scoreboard, one bit per register:
  - Edge priority per register: clear engine > sb_set > effective write.
  - sb_set=1 in IDLE sets pend[sb_addr].
  - An effective write clears pend[wa].
  - sb_set and a write to the same address in the same cycle leave the bit set (the new producer wins).
  - sb_set with sb_addr=0 is ignored when ZERO_REG=1.
  - busyp = pend[rap], except 0 when BYPASS=1 and an effective write targets rap this cycle. busyp = 0 for address 0 when ZERO_REG=1.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, counter=0.
  - CLEAR: clr_busy=1. Each cycle writes 0 to register[counter], clears pend[counter], increments counter. At counter = NREG-1, after clearing, -> DONE.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle -> IDLE. A clr_req held high then restarts a clear.
  - Latency: clr_busy high for NREG cycles starting the cycle after the clr_req edge; clr_done follows immediately.
  - During CLEAR and DONE: we, sb_set and clr_req are ignored (dropped, not queued); bypass is disabled; reads return current storage (partially cleared).
  - Counter is ADDR_W bits; terminal detection at all-ones, with no wrap into a second pass.
- Reset asserted mid-clear: immediate return to IDLE, all state zeroed, no clr_done pulse.

Test Plan:
- Reset, then write wa=5, wd=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF. ra2=0 -> rd2=0.
- BYPASS=1: same cycle we=1, wa=7, wd=0x12345678, ra1=7 -> rd1=0x12345678 and busy1=0. With BYPASS=0: rd1 = old value 0.
- ZERO_REG: write wa=0, wd=0xFFFFFFFF and sb_set with sb_addr=0 -> rd1 (ra1=0)=0 and busy1=0 on all following cycles.
- Scoreboard: sb_set with sb_addr=3 -> busy1 (ra1=3)=1 next cycle. Later, sb_set addr 3 and write wa=3 in the same cycle -> busy1 stays 1. Write wa=3 alone -> busy1=0.
- Clear: fill r1..r31 with nonzero values and pend r9, then pulse clr_req -> clr_busy high 32 cycles, clr_done high 1 cycle. A write during CLEAR is dropped. Afterwards all reads are 0 and busy is 0.
- Drive rst=0 at clear cycle 10 (mid-clear) -> outputs drop to 0 asynchronously. After release, FSM is IDLE with no clr_done, and a fresh write works.

Source files
------------

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Parametrised register file with two combinational read ports, one
// synchronous write port, optional write-to-read bypass, a per-register
// pending-write scoreboard and a sequential clear engine.
//
// Ports:
//   clk                 clock, all state updates on rising edge
//   rst                 asynchronous active-low reset
//   ra1, ra2            read addresses
//   rd1, rd2            read data (combinational)
//   we, wa, wd          write enable / address / data
//   sb_set, sb_addr     mark register sb_addr as pending
//   busy1, busy2        pending status of ra1 / ra2 (combinational)
//   clr_req             request sequential clear of all registers
//   clr_busy            clear engine active (registered)
//   clr_done            one-cycle pulse when clear completes (registered)
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic              clr_busy_q, clr_done_q;

  logic idle_s;
  logic clearing_s;
  logic wr_eff_s;
  logic sb_eff_s;

  // True when address targets the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // True when an effective write this cycle should be forwarded to a read of addr.
  function automatic logic bypass_hit(input logic                wr_eff,
                                      input logic [ADDR_W-1:0] waddr,
                                      input logic [ADDR_W-1:0] raddr);
    return (BYPASS != 0) && wr_eff && (waddr == raddr);
  endfunction

  // Qualify write / scoreboard requests: only honoured in IDLE, never for r0.
  always_comb begin
    idle_s     = (state_q == S_IDLE);
    clearing_s = (state_q == S_CLEAR);
    wr_eff_s   = we && idle_s && !is_zero_reg(wa);
    sb_eff_s   = sb_set && idle_s && !is_zero_reg(sb_addr);
  end

  // Clear FSM next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        // Terminal at all-ones; counter parks at zero rather than starting a second pass.
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = S_DONE;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        // clr_req here is dropped; a level still high next cycle restarts from IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Scoreboard next state: clear engine > sb_set > effective write.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (clearing_s && (cnt_q == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
      end else if (sb_eff_s && (sb_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end else if (wr_eff_s && (wa == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // FSM, counter, scoreboard and handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {ADDR_W{1'b0}};
      pend_q     <= {NREG{1'b0}};
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      clr_busy_q <= (state_d == S_CLEAR);
      clr_done_q <= (state_d == S_DONE);
    end
  end

  // Register storage: clear engine writes zero, otherwise the write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (clearing_s) begin
      regs_q[cnt_q] <= {DATA_W{1'b0}};
    end else if (wr_eff_s) begin
      regs_q[wa] <= wd;
    end else begin
      regs_q[wa] <= regs_q[wa];
    end
  end

  // Read ports: zero register wins over bypass, bypass wins over storage.
  always_comb begin
    if (is_zero_reg(ra1)) begin
      rd1   = {DATA_W{1'b0}};
      busy1 = 1'b0;
    end else if (bypass_hit(wr_eff_s, wa, ra1)) begin
      rd1   = wd;
      busy1 = 1'b0;
    end else begin
      rd1   = regs_q[ra1];
      busy1 = pend_q[ra1];
    end

    if (is_zero_reg(ra2)) begin
      rd2   = {DATA_W{1'b0}};
      busy2 = 1'b0;
    end else if (bypass_hit(wr_eff_s, wa, ra2)) begin
      rd2   = wd;
      busy2 = 1'b0;
    end else begin
      rd2   = regs_q[ra2];
      busy2 = pend_q[ra2];
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, sb_addr;
  logic [31:0] wd;
  logic        we, sb_set, clr_req;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, clr_busy, clr_done;
  logic        nb_busy1, nb_busy2, nb_clr_busy, nb_clr_done;

  int total = 0;
  int bad   = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1), .busy2(busy2), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(nb_busy1), .busy2(nb_busy2), .clr_req(clr_req),
    .clr_busy(nb_clr_busy), .clr_done(nb_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int busy_cnt;
  int done_cnt;
  int done_k;

  initial begin
    rst = 1'b0; ra1 = 5'd0; ra2 = 5'd0; wa = 5'd0; wd = 32'd0;
    we = 1'b0; sb_set = 1'b0; sb_addr = 5'd0; clr_req = 1'b0;
    #3;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
    #9 rst = 1'b1;
    tick();

    // basic write then read through storage
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd0;
    tick();
    we = 1'b0; #1;
    chk("wr5_rd1", rd1, 32'hDEADBEEF);
    chk("wr5_rd2_zero", rd2, 32'd0);
    chk("wr5_nb_rd1", nb_rd1, 32'hDEADBEEF);

    // bypass of same-cycle write
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra1 = 5'd7; ra2 = 5'd7; #1;
    chk("byp_rd1", rd1, 32'h12345678);
    chk("byp_rd2", rd2, 32'h12345678);
    chk("byp_busy1", {31'd0, busy1}, 32'd0);
    chk("nobyp_rd1", nb_rd1, 32'd0);
    tick();
    we = 1'b0; #1;
    chk("nobyp_rd1_next", nb_rd1, 32'h12345678);

    // bypass also masks busy of a pending register
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0; #1;
    chk("pend7_busy1", {31'd0, busy1}, 32'd1);
    chk("pend7_nb_busy1", {31'd0, nb_busy1}, 32'd1);
    we = 1'b1; wa = 5'd7; wd = 32'h0000AAAA; #1;
    chk("byp_busy_mask", {31'd0, busy1}, 32'd0);
    chk("nobyp_busy_kept", {31'd0, nb_busy1}, 32'd1);
    tick();
    we = 1'b0; #1;
    chk("pend7_cleared", {31'd0, busy1}, 32'd0);
    chk("wr7_rd1", rd1, 32'h0000AAAA);

    // zero register: writes and sb_set ignored
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; sb_set = 1'b1; sb_addr = 5'd0; ra1 = 5'd0; #1;
    chk("zero_rd1_same", rd1, 32'd0);
    chk("zero_busy1_same", {31'd0, busy1}, 32'd0);
    tick();
    we = 1'b0; sb_set = 1'b0; #1;
    chk("zero_rd1_next", rd1, 32'd0);
    chk("zero_busy1_next", {31'd0, busy1}, 32'd0);
    tick();
    chk("zero_rd1_later", rd1, 32'd0);
    chk("zero_busy1_later", {31'd0, busy1}, 32'd0);

    // scoreboard priority
    sb_set = 1'b1; sb_addr = 5'd3; ra1 = 5'd3; ra2 = 5'd3;
    tick();
    sb_set = 1'b0; #1;
    chk("sb3_busy1", {31'd0, busy1}, 32'd1);
    chk("sb3_busy2", {31'd0, busy2}, 32'd1);
    sb_set = 1'b1; sb_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h00000033;
    tick();
    sb_set = 1'b0; we = 1'b0; #1;
    chk("sb3_wr_busy_kept", {31'd0, busy1}, 32'd1);
    chk("sb3_wr_rd1", rd1, 32'h00000033);
    we = 1'b1; wa = 5'd3; wd = 32'h00000044;
    tick();
    we = 1'b0; #1;
    chk("sb3_wr_alone_busy", {31'd0, busy1}, 32'd0);

    // fill r1..r31 and pend r9
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'h01010101 * 32'(i);
      tick();
    end
    we = 1'b0;
    sb_set = 1'b1; sb_addr = 5'd9;
    tick();
    sb_set = 1'b0; ra1 = 5'd9; #1;
    chk("fill_busy9", {31'd0, busy1}, 32'd1);
    chk("fill_rd9", rd1, 32'h09090909);

    // sequential clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 4) begin
        we = 1'b1; wa = 5'd1; wd = 32'h00000BAD; ra1 = 5'd1; ra2 = 5'd31; #1;
        chk("clr_no_bypass", rd1, 32'd0);
        chk("clr_partial_r31", rd2, 32'h1F1F1F1F);
      end else begin
        we = 1'b0;
      end
      tick();
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    chk("clr_done_pos", 32'(done_k), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); #1;
      chk("post_clr_rd1", rd1, 32'd0);
      chk("post_clr_busy2", {31'd0, busy2}, 32'd0);
    end

    // reset in the middle of a clear
    we = 1'b1; wa = 5'd31; wd = 32'h00000031;
    tick();
    we = 1'b0; sb_set = 1'b1; sb_addr = 5'd31;
    tick();
    sb_set = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    ra1 = 5'd31; #1;
    chk("mid_clr_busy", {31'd0, clr_busy}, 32'd1);
    chk("mid_rd31", rd1, 32'h00000031);
    chk("mid_busy31", {31'd0, busy1}, 32'd1);
    rst = 1'b0; #1;
    chk("arst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("arst_rd31", rd1, 32'd0);
    chk("arst_busy31", {31'd0, busy1}, 32'd0);
    #2 rst = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end
    chk("arst_no_busy", 32'(busy_cnt), 32'd0);
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    we = 1'b1; wa = 5'd6; wd = 32'h00000066; ra1 = 5'd6;
    tick();
    we = 1'b0; #1;
    chk("arst_fresh_wr", rd1, 32'h00000066);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
